// File: rtl/mi_burst_initiator.sv
// rtl/mi_burst_initiator.sv - single-burst initiator bridging a host line buffer to the MI port
//
// Purpose:
//   Accepts one host command at a time, issues it as a single MI burst command,
//   then streams line-buffer words out (write burst) or captures read beats into
//   the line buffer (read burst). Completion is a one-cycle done pulse with an
//   err status that stays valid until the next command is accepted.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_valid_i/ready_o   host command handshake (ready only while idle)
//   cmd_rw_i              1 = read burst, 0 = write burst
//   cmd_addr_i            first MI word address
//   cmd_len_i             beat count minus one
//   done_o, err_o         completion pulse and sticky completion status
//   buf_we_i/widx_i/wdata_i  host write port into the line buffer
//   buf_ridx_i/rdata_o    host combinational read port of the line buffer
//   mi_addr_o/len_o/rw_o  MI burst command fields, mi_valid_o/mi_ready_i handshake
//   mi_wdata_o            current write beat (buffer word at the beat index)
//   mi_wack_i/wlast_i     write beat consumed / final write beat
//   mi_rdata_i/rstb_i/rlast_i  read beat data / strobe / final read beat

module mi_burst_initiator #(
  parameter int AW      = 20,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4095,
  localparam int LW     = $clog2(DEPTH),
  localparam int CW     = LW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // host command
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_rw_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [LW-1:0] cmd_len_i,
  output logic          done_o,
  output logic          err_o,
  // host line buffer
  input  logic          buf_we_i,
  input  logic [LW-1:0] buf_widx_i,
  input  logic [31:0]   buf_wdata_i,
  input  logic [LW-1:0] buf_ridx_i,
  output logic [31:0]   buf_rdata_o,
  // MI initiator
  output logic [AW-1:0] mi_addr_o,
  output logic [6:0]    mi_len_o,
  output logic          mi_rw_o,
  output logic          mi_valid_o,
  input  logic          mi_ready_i,
  output logic [31:0]   mi_wdata_o,
  input  logic          mi_wack_i,
  input  logic          mi_wlast_i,
  input  logic [31:0]   mi_rdata_i,
  input  logic          mi_rstb_i,
  input  logic          mi_rlast_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] IDX_MAX  = CW'(DEPTH - 1);
  localparam logic [11:0]   TMO_LAST = 12'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [6:0]    len_q, len_d;
  logic          rw_q, rw_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   tmo_q, tmo_d;
  logic          sticky_q, sticky_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH];

  logic          in_burst;
  logic          in_data;
  logic          mi_evt;
  logic          tmo_hit;
  logic          beat;
  logic          wrong_dir;
  logic          last_beat;
  logic          in_range;
  logic          final_err;
  logic          rd_wr;
  logic [7:0]    cnt_ext;
  logic [7:0]    len_ext;

  // Datapath helpers
  assign in_burst  = (state_q == S_CMD) || (state_q == S_DATA);
  assign in_data   = (state_q == S_DATA);
  // Any MI activity restarts the idle watchdog, even a strobe of the wrong direction.
  assign mi_evt    = mi_ready_i | mi_wack_i | mi_rstb_i;
  assign tmo_hit   = in_burst && !mi_evt && (tmo_q == TMO_LAST);

  // Beats only count in DATA; strobes in IDLE/CMD/DONE are simply dropped.
  assign beat      = in_data && (rw_q ? mi_rstb_i : mi_wack_i);
  assign wrong_dir = in_data && (rw_q ? mi_wack_i : mi_rstb_i);
  assign last_beat = beat && (rw_q ? mi_rlast_i : mi_wlast_i);

  assign cnt_ext   = 8'(cnt_q);
  assign len_ext   = {1'b0, len_q};
  // cnt_q counts beats already taken, so this beat is number cnt_q+1.
  assign in_range  = (cnt_ext <= len_ext);
  // Final beat must be beat number len+1, i.e. cnt_q == len before it lands.
  assign final_err = sticky_q | wrong_dir | (cnt_ext != len_ext);

  // Read beats own the buffer write port; an in-flight host write that cycle is dropped.
  assign rd_wr     = beat && rw_q && in_range && !rst_i;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    rw_d     = rw_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    sticky_d = sticky_q;
    err_d    = err_q;

    if (in_burst) begin
      tmo_d = mi_evt ? 12'd0 : (tmo_q + 12'd1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d   = cmd_addr_i;
          len_d    = 7'(cmd_len_i);
          rw_d     = cmd_rw_i;
          idx_d    = '0;
          cnt_d    = '0;
          tmo_d    = '0;
          sticky_d = 1'b0;
          err_d    = 1'b0;
          state_d  = S_CMD;
        end
      end

      S_CMD: begin
        if (mi_ready_i) begin
          tmo_d   = '0;
          state_d = S_DATA;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DATA: begin
        if (beat && in_range) begin
          cnt_d = cnt_q + CW'(1);
          // Saturate so the last legal beat leaves the index on the final word.
          if (idx_q != IDX_MAX) begin
            idx_d = idx_q + CW'(1);
          end
        end
        if ((beat && !in_range) || wrong_dir) begin
          sticky_d = 1'b1;
        end
        if (last_beat) begin
          err_d   = final_err;
          state_d = S_DONE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      rw_q     <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      sticky_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      rw_q     <= rw_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
    end
  end

  // Line buffer: contents are not reset.
  always_ff @(posedge clk_i) begin
    if (rd_wr) begin
      mem[idx_q[LW-1:0]] <= mi_rdata_i;
    end else if (buf_we_i) begin
      mem[buf_widx_i] <= buf_wdata_i;
    end
  end

  // Outputs; handshake/status outputs are forced low while reset is held.
  assign cmd_ready_o = (state_q == S_IDLE) && !rst_i;
  assign mi_valid_o  = (state_q == S_CMD) && !rst_i;
  assign done_o      = (state_q == S_DONE) && !rst_i;
  assign err_o       = err_q && !rst_i;

  assign mi_addr_o   = addr_q;
  assign mi_len_o    = len_q;
  assign mi_rw_o     = rw_q;
  assign mi_wdata_o  = mem[idx_q[LW-1:0]];
  assign buf_rdata_o = mem[buf_ridx_i];

endmodule
